// File: rtl/miaow_dispatch_pkg.sv
// Shared widths, slot-table entry type and launch helpers for the dispatcher-to-CU protocol.
package miaow_dispatch_pkg;

    localparam int TAG_W          = 15;
    localparam int VGPR_BASE_W    = 10;
    localparam int SGPR_BASE_W    = 9;
    localparam int LDS_BASE_W     = 16;
    localparam int PC_W           = 32;
    localparam int WFSIZE_W       = 6;
    localparam int WGCNT_W        = 4;
    localparam int EXEC_W         = 64;
    localparam int NUM_WF_DEFAULT = 40;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [VGPR_BASE_W-1:0] vgpr_base;
        logic [SGPR_BASE_W-1:0] sgpr_base;
        logic [LDS_BASE_W-1:0]  lds_base;
        logic [WFSIZE_W-1:0]    wf_size;
        logic [WGCNT_W-1:0]     wg_count;
    } wf_entry_t;

    // Size is threads-1; a full 64-thread wave would overflow the shift, so it is special-cased.
    function automatic logic [EXEC_W-1:0] exec_mask(input logic [WFSIZE_W-1:0] size);
        if (size == '1) begin
            return '1;
        end
        return (64'd1 << ({1'b0, size} + 7'd1)) - 64'd1;
    endfunction

endpackage

// File: rtl/wf_slot_alloc.sv
// Find-first-zero over the slot valid vector: reports whether any slot is free and the lowest free index.
module wf_slot_alloc #(
    parameter int N = 40,
    parameter int W = 6
) (
    input  logic [N-1:0] valid_i,
    output logic         free_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        free_o = 1'b0;
        idx_o  = '0;
        // Scan downward so the last assignment wins with the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_o = 1'b1;
                idx_o  = i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cu_dispatch_receiver.sv
// CU-side wavefront dispatch endpoint: allocates slots, launches wavefronts into fetch and
// returns the dispatcher tag when a wavefront halts.
module cu_dispatch_receiver
    import miaow_dispatch_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEFAULT,
    parameter int WFID_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch2cu_wf_dispatch,
    input  logic [WGCNT_W-1:0]     dispatch2cu_wg_wf_count,
    input  logic [WFSIZE_W-1:0]    dispatch2cu_wf_size_dispatch,
    input  logic [SGPR_BASE_W-1:0] dispatch2cu_sgpr_base_dispatch,
    input  logic [VGPR_BASE_W-1:0] dispatch2cu_vgpr_base_dispatch,
    input  logic [TAG_W-1:0]       dispatch2cu_wf_tag_dispatch,
    input  logic [LDS_BASE_W-1:0]  dispatch2cu_lds_base_dispatch,
    input  logic [PC_W-1:0]        dispatch2cu_start_pc_dispatch,
    input  logic                   wf_halt,
    input  logic [WFID_W-1:0]      wf_halt_id,
    input  logic [WFID_W-1:0]      tbl_rd_id,
    output logic                   new_wf_valid,
    output logic [WFID_W-1:0]      new_wf_id,
    output logic [PC_W-1:0]        new_wf_pc,
    output logic [EXEC_W-1:0]      new_wf_exec_mask,
    output logic [WGCNT_W-1:0]     new_wf_wg_count,
    output logic [VGPR_BASE_W-1:0] tbl_rd_vgpr_base,
    output logic [SGPR_BASE_W-1:0] tbl_rd_sgpr_base,
    output logic [LDS_BASE_W-1:0]  tbl_rd_lds_base,
    output logic                   cu2dispatch_wf_done,
    output logic [TAG_W-1:0]       cu2dispatch_wf_tag_done,
    output logic [WFID_W:0]        active_count,
    output logic                   cu_full,
    output logic                   err_overflow,
    output logic                   err_bad_halt
);

    logic [NUM_WF-1:0] valid_q, valid_d;
    wf_entry_t         table_q [NUM_WF];
    wf_entry_t         entry_in, rd_entry;
    logic              slot_free, alloc, halt_hit, halt_ok;
    logic [WFID_W-1:0] free_idx;
    logic [TAG_W-1:0]  halt_tag;
    logic [WFID_W:0]   count_d;

    wf_slot_alloc #(.N(NUM_WF), .W(WFID_W)) u_alloc (
        .valid_i (valid_q),
        .free_o  (slot_free),
        .idx_o   (free_idx)
    );

    assign alloc = dispatch2cu_wf_dispatch && slot_free;

    assign entry_in = '{
        tag:       dispatch2cu_wf_tag_dispatch,
        vgpr_base: dispatch2cu_vgpr_base_dispatch,
        sgpr_base: dispatch2cu_sgpr_base_dispatch,
        lds_base:  dispatch2cu_lds_base_dispatch,
        wf_size:   dispatch2cu_wf_size_dispatch,
        wg_count:  dispatch2cu_wg_wf_count
    };

    // Halt ids beyond NUM_WF never match, so they fall through as a bad halt.
    always_comb begin
        halt_hit = 1'b0;
        halt_tag = '0;
        rd_entry = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (wf_halt_id == i[WFID_W-1:0]) begin
                halt_hit = valid_q[i];
                halt_tag = table_q[i].tag;
            end
            if (tbl_rd_id == i[WFID_W-1:0]) begin
                rd_entry = table_q[i];
            end
        end
    end

    assign halt_ok = wf_halt && halt_hit;

    // Allocation sees pre-edge valid bits, so a slot halting this cycle cannot be reused yet.
    always_comb begin
        valid_d = valid_q;
        if (halt_ok) begin
            valid_d[wf_halt_id] = 1'b0;
        end
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
        end
        count_d = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            count_d = count_d + {{WFID_W{1'b0}}, valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q                 <= '0;
            new_wf_valid            <= 1'b0;
            new_wf_id               <= '0;
            new_wf_pc               <= '0;
            new_wf_exec_mask        <= '0;
            new_wf_wg_count         <= '0;
            cu2dispatch_wf_done     <= 1'b0;
            cu2dispatch_wf_tag_done <= '0;
            active_count            <= '0;
            cu_full                 <= 1'b0;
            err_overflow            <= 1'b0;
            err_bad_halt            <= 1'b0;
        end else begin
            valid_q             <= valid_d;
            new_wf_valid        <= alloc;
            cu2dispatch_wf_done <= halt_ok;
            active_count        <= count_d;
            cu_full             <= &valid_d;
            if (alloc) begin
                new_wf_id        <= free_idx;
                new_wf_pc        <= dispatch2cu_start_pc_dispatch;
                new_wf_exec_mask <= exec_mask(dispatch2cu_wf_size_dispatch);
                new_wf_wg_count  <= dispatch2cu_wg_wf_count;
            end
            if (halt_ok) begin
                cu2dispatch_wf_tag_done <= halt_tag;
            end
            if (dispatch2cu_wf_dispatch && !slot_free) begin
                err_overflow <= 1'b1;
            end
            if (wf_halt && !halt_hit) begin
                err_bad_halt <= 1'b1;
            end
        end
    end

    // Payload needs no reset; an entry is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc) begin
            table_q[free_idx] <= entry_in;
        end
    end

    assign tbl_rd_vgpr_base = rd_entry.vgpr_base;
    assign tbl_rd_sgpr_base = rd_entry.sgpr_base;
    assign tbl_rd_lds_base  = rd_entry.lds_base;

endmodule

// File: tb/tb_cu_dispatch_receiver.sv
// Scoreboard bench for cu_dispatch_receiver: launches and done pulses are checked against queued expectations.
module tb_cu_dispatch_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp;
    logic [3:0]  wg_cnt;
    logic [5:0]  wf_size;
    logic [8:0]  sgpr_b;
    logic [9:0]  vgpr_b;
    logic [14:0] tag_in;
    logic [15:0] lds_b;
    logic [31:0] pc_in;
    logic        halt;
    logic [5:0]  halt_id;
    logic [5:0]  rd_id;
    logic        nv;
    logic [5:0]  nid;
    logic [31:0] npc;
    logic [63:0] nmask;
    logic [3:0]  nwg;
    logic [9:0]  rd_vgpr;
    logic [8:0]  rd_sgpr;
    logic [15:0] rd_lds;
    logic        done;
    logic [14:0] done_tag;
    logic [6:0]  act;
    logic        full;
    logic        e_ovf;
    logic        e_bad;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] pc;
        logic [63:0] mask;
        logic [3:0]  wg;
    } launch_t;

    launch_t     lq[$];
    logic [14:0] dq[$];

    cu_dispatch_receiver dut (
        .clk                            (clk),
        .rst                            (rst),
        .dispatch2cu_wf_dispatch        (disp),
        .dispatch2cu_wg_wf_count        (wg_cnt),
        .dispatch2cu_wf_size_dispatch   (wf_size),
        .dispatch2cu_sgpr_base_dispatch (sgpr_b),
        .dispatch2cu_vgpr_base_dispatch (vgpr_b),
        .dispatch2cu_wf_tag_dispatch    (tag_in),
        .dispatch2cu_lds_base_dispatch  (lds_b),
        .dispatch2cu_start_pc_dispatch  (pc_in),
        .wf_halt                        (halt),
        .wf_halt_id                     (halt_id),
        .tbl_rd_id                      (rd_id),
        .new_wf_valid                   (nv),
        .new_wf_id                      (nid),
        .new_wf_pc                      (npc),
        .new_wf_exec_mask               (nmask),
        .new_wf_wg_count                (nwg),
        .tbl_rd_vgpr_base               (rd_vgpr),
        .tbl_rd_sgpr_base               (rd_sgpr),
        .tbl_rd_lds_base                (rd_lds),
        .cu2dispatch_wf_done            (done),
        .cu2dispatch_wf_tag_done        (done_tag),
        .active_count                   (act),
        .cu_full                        (full),
        .err_overflow                   (e_ovf),
        .err_bad_halt                   (e_bad)
    );

    always #5 clk = ~clk;

    // Bases are derived from the tag so a lookup can be checked from the tag alone.
    function automatic logic [9:0]  vb(input logic [14:0] t); return t[9:0]; endfunction
    function automatic logic [8:0]  sb(input logic [14:0] t); return t[8:0] ^ 9'h0AA; endfunction
    function automatic logic [15:0] lb(input logic [14:0] t); return {1'b0, t} + 16'h1000; endfunction

    always @(negedge clk) begin
        if (nv === 1'b1) begin
            checks++;
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected: got id=%0d pc=%h, none expected", nid, npc);
            end else begin
                launch_t e;
                e = lq.pop_front();
                if ({nid, npc, nmask, nwg} !== e) begin
                    errors++;
                    $display("FAIL launch: got id=%0d pc=%h mask=%h wg=%0d, want id=%0d pc=%h mask=%h wg=%0d",
                             nid, npc, nmask, nwg, e.id, e.pc, e.mask, e.wg);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got tag=%h, none expected", done_tag);
            end else begin
                logic [14:0] et;
                et = dq.pop_front();
                if (done_tag !== et) begin
                    errors++;
                    $display("FAIL done_tag: got %h, want %h", done_tag, et);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        disp = 1'b0;
        halt = 1'b0;
    endtask

    // exp_id < 0 means the dispatch must not launch.
    task automatic dispatch(input logic [14:0] t, input logic [5:0] sz, input logic [31:0] pc,
                            input logic [3:0] wg, input int exp_id, input logic [63:0] exp_mask);
        disp    = 1'b1;
        tag_in  = t;
        wf_size = sz;
        pc_in   = pc;
        wg_cnt  = wg;
        vgpr_b  = vb(t);
        sgpr_b  = sb(t);
        lds_b   = lb(t);
        if (exp_id >= 0) begin
            lq.push_back('{id: exp_id[5:0], pc: pc, mask: exp_mask, wg: wg});
        end
    endtask

    task automatic do_halt(input logic [5:0] id, input bit expect_done, input logic [14:0] t);
        halt    = 1'b1;
        halt_id = id;
        if (expect_done) begin
            dq.push_back(t);
        end
    endtask

    initial begin
        rst = 1'b1; disp = 1'b0; halt = 1'b0; halt_id = '0; rd_id = '0;
        wg_cnt = '0; wf_size = '0; sgpr_b = '0; vgpr_b = '0; tag_in = '0; lds_b = '0; pc_in = '0;
        repeat (3) tick();
        chk("reset_new_wf_valid", {63'd0, nv}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_active", {57'd0, act}, 64'd0);
        chk("reset_errs", {62'd0, e_ovf, e_bad}, 64'd0);
        rst = 1'b0;
        tick();

        dispatch(15'h1234, 6'd63, 32'h100, 4'd1, 0, '1);
        tick();
        chk("first_active", {57'd0, act}, 64'd1);
        chk("first_full", {63'd0, full}, 64'd0);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rereset_active", {57'd0, act}, 64'd0);

        dispatch(15'h0A0, 6'd0,  32'h200, 4'd2, 0, 64'h1);                  tick();
        dispatch(15'h0A1, 6'd31, 32'h204, 4'd2, 1, 64'hFFFF_FFFF);          tick();
        dispatch(15'h0A2, 6'd62, 32'h208, 4'd2, 2, 64'h7FFF_FFFF_FFFF_FFFF); tick();
        chk("b2b_active", {57'd0, act}, 64'd3);

        for (int i = 3; i < 40; i++) begin
            dispatch(15'h100 + 15'(i), 6'd63, 32'h1000 + 32'(i * 4), 4'd4, i, '1);
            tick();
        end
        chk("fill_active", {57'd0, act}, 64'd40);
        chk("fill_full", {63'd0, full}, 64'd1);
        chk("fill_no_ovf", {63'd0, e_ovf}, 64'd0);

        dispatch(15'h7FF, 6'd63, 32'h9999, 4'd1, -1, '0);
        tick();
        chk("ovf_flag", {63'd0, e_ovf}, 64'd1);
        chk("ovf_active", {57'd0, act}, 64'd40);
        rd_id = 6'd39; #1;
        chk("lookup39_vgpr", {54'd0, rd_vgpr}, {54'd0, vb(15'h127)});
        chk("lookup39_sgpr", {55'd0, rd_sgpr}, {55'd0, sb(15'h127)});
        chk("lookup39_lds",  {48'd0, rd_lds},  {48'd0, lb(15'h127)});

        do_halt(6'd2, 1'b1, 15'h0A2);
        dispatch(15'h333, 6'd1, 32'h500, 4'd1, -1, '0);
        tick();
        chk("halt2_active", {57'd0, act}, 64'd39);
        chk("halt2_full", {63'd0, full}, 64'd0);
        dispatch(15'h222, 6'd5, 32'h300, 4'd3, 2, 64'h3F);
        tick();
        chk("reuse2_active", {57'd0, act}, 64'd40);

        do_halt(6'd5, 1'b1, 15'h105);
        tick();
        chk("halt5_active", {57'd0, act}, 64'd39);
        chk("halt5_no_bad", {63'd0, e_bad}, 64'd0);
        do_halt(6'd5, 1'b0, '0);
        tick();
        chk("badhalt_flag", {63'd0, e_bad}, 64'd1);
        chk("badhalt_active", {57'd0, act}, 64'd39);
        rd_id = 6'd2; #1;
        chk("lookup2_vgpr", {54'd0, rd_vgpr}, {54'd0, vb(15'h222)});
        chk("lookup2_lds",  {48'd0, rd_lds},  {48'd0, lb(15'h222)});

        rst = 1'b1; tick(); rst = 1'b0;
        dispatch(15'h011, 6'd7, 32'h40, 4'd3, 0, 64'hFF); tick();
        dispatch(15'h012, 6'd7, 32'h44, 4'd3, 1, 64'hFF); tick();
        dispatch(15'h013, 6'd7, 32'h48, 4'd3, 2, 64'hFF); tick();
        chk("pre_rst_active", {57'd0, act}, 64'd3);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("rst_active", {57'd0, act}, 64'd0);
        chk("rst_errs", {62'd0, e_ovf, e_bad}, 64'd0);
        dispatch(15'h044, 6'd15, 32'h80, 4'd1, 0, 64'hFFFF);
        tick();
        chk("post_rst_active", {57'd0, act}, 64'd1);

        do_halt(6'd45, 1'b0, '0);
        tick();
        chk("halt_oob_flag", {63'd0, e_bad}, 64'd1);
        chk("halt_oob_active", {57'd0, act}, 64'd1);

        repeat (3) tick();
        chk("launch_queue_drained", 64'(lq.size()), 64'd0);
        chk("done_queue_drained", 64'(dq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
